// File: rtl/recip_pkg.sv
// Shared field widths, IEEE-754 constants and operand classes for the reciprocal divider.
package recip_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  // Seed constants carry 40 fractional bits; each user shifts down to its own FRAC_W.
  localparam int          SEED_FRAC = 40;
  localparam logic [63:0] C48_17    = (64'd48 << SEED_FRAC) / 64'd17;
  localparam logic [63:0] C32_17    = (64'd32 << SEED_FRAC) / 64'd17;

  typedef enum logic [1:0] {NORMAL, ZERO, INF, NAN} cls_e;
endpackage

// File: rtl/nr_stage.sv
// One registered Newton-Raphson step x' = x*(2 - D*x); operand side-band rides alongside.
module nr_stage
  import recip_pkg::*;
#(
  parameter int FRAC_W = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_sign,
  input  logic signed [9:0]   i_exp,
  input  cls_e                i_cls,
  input  logic [MAN_W-1:0]    i_mn,
  input  logic [FRAC_W-1:0]   i_d,
  input  logic [FRAC_W+1:0]   i_x,
  output logic                o_sign,
  output logic signed [9:0]   o_exp,
  output cls_e                o_cls,
  output logic [MAN_W-1:0]    o_mn,
  output logic [FRAC_W-1:0]   o_d,
  output logic [FRAC_W+1:0]   o_x
);
  localparam int            XW  = FRAC_W + 2;
  localparam logic [XW-1:0] TWO = {2'b10, {FRAC_W{1'b0}}};

  function automatic logic [XW-1:0] mul_fx(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return XW'(({{XW{1'b0}}, a} * {{XW{1'b0}}, b}) >> FRAC_W);
  endfunction

  logic [XW-1:0] w_p;
  logic [XW-1:0] w_t;

  assign w_p = mul_fx(XW'(i_d), i_x);
  assign w_t = TWO - w_p;

  logic               r_sign;
  logic signed [9:0]  r_exp;
  cls_e               r_cls;
  logic [MAN_W-1:0]   r_mn;
  logic [FRAC_W-1:0]  r_d;
  logic [XW-1:0]      r_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_cls  <= NORMAL;
      r_mn   <= '0;
      r_d    <= '0;
      r_x    <= '0;
    end else begin
      r_sign <= i_sign;
      r_exp  <= i_exp;
      r_cls  <= i_cls;
      r_mn   <= i_mn;
      r_d    <= i_d;
      r_x    <= mul_fx(i_x, w_t);
    end
  end

  assign o_sign = r_sign;
  assign o_exp  = r_exp;
  assign o_cls  = r_cls;
  assign o_mn   = r_mn;
  assign o_d    = r_d;
  assign o_x    = r_x;
endmodule

// File: rtl/reciprocal.sv
// Pipelined binary32 divider: Newton-Raphson reciprocal of the divisor times the numerator.
module reciprocal
  import recip_pkg::*;
#(
  parameter int ITERATIONS = 3,
  parameter int FRAC_W     = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] numerator,
  input  logic [31:0] divisor,
  output logic [31:0] reciprocal1
);
  localparam int                XW   = FRAC_W + 2;
  localparam int                PW   = FRAC_W + MAN_W + 2;
  localparam logic [XW-1:0]     C48  = XW'(C48_17 >> (SEED_FRAC - FRAC_W));
  localparam logic [XW-1:0]     C32  = XW'(C32_17 >> (SEED_FRAC - FRAC_W));
  localparam logic [XW-1:0]     TWO  = {2'b10, {FRAC_W{1'b0}}};
  localparam logic [FRAC_W-1:0] HALF = {1'b1, {(FRAC_W-1){1'b0}}};

  function automatic logic [XW-1:0] mul_fx(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return XW'(({{XW{1'b0}}, a} * {{XW{1'b0}}, b}) >> FRAC_W);
  endfunction

  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] f, input logic g,
                                               input logic s);
    return {1'b0, f} + (MAN_W+1)'(g & (s | f[0]));
  endfunction

  function automatic logic [31:0] pack_fp(input logic sign, input cls_e cls,
                                          input logic signed [9:0] e, input logic [MAN_W-1:0] f);
    case (cls)
      NAN:     return QNAN;
      INF:     return {sign, POS_INF[30:0]};
      ZERO:    return {sign, 31'd0};
      default: begin
        if (e > 10'sd254)    return {sign, POS_INF[30:0]};
        else if (e < 10'sd1) return {sign, 31'd0};
        else                 return {sign, e[EXP_W-1:0], f};
      end
    endcase
  endfunction

  logic [EXP_W-1:0]  w_n_exp, w_d_exp;
  logic [MAN_W-1:0]  w_n_frac, w_d_frac;
  logic              w_n_zero, w_n_inf, w_n_nan, w_d_zero, w_d_inf, w_d_nan;
  logic signed [9:0] w_exp_p0;
  logic [FRAC_W-1:0] w_d_fx;
  logic [XW-1:0]     w_x0;
  cls_e              w_cls_p0;

  assign w_n_exp  = numerator[30:23];
  assign w_d_exp  = divisor[30:23];
  assign w_n_frac = numerator[22:0];
  assign w_d_frac = divisor[22:0];
  // Subnormals flush to zero simply by keying zero on the exponent field alone.
  assign w_n_zero = (w_n_exp == '0);
  assign w_d_zero = (w_d_exp == '0);
  assign w_n_inf  = (w_n_exp == '1) && (w_n_frac == '0);
  assign w_d_inf  = (w_d_exp == '1) && (w_d_frac == '0);
  assign w_n_nan  = (w_n_exp == '1) && (w_n_frac != '0);
  assign w_d_nan  = (w_d_exp == '1) && (w_d_frac != '0);
  assign w_exp_p0 = $signed({2'b00, w_n_exp}) - $signed({2'b00, w_d_exp}) + $signed(10'(BIAS - 1));
  assign w_d_fx   = FRAC_W'({1'b1, w_d_frac}) << (FRAC_W - MAN_W - 1);
  assign w_x0     = C48 - mul_fx(C32, XW'(w_d_fx));

  always_comb begin
    w_cls_p0 = NORMAL;
    if (w_n_nan || w_d_nan || (w_n_zero && w_d_zero) || (w_n_inf && w_d_inf))
      w_cls_p0 = NAN;
    else if (w_d_zero || w_n_inf)
      w_cls_p0 = INF;
    else if (w_d_inf || w_n_zero)
      w_cls_p0 = ZERO;
  end

  // Stage 1 boundary: classified operands and linear seed
  logic              r_sign_p0;
  logic signed [9:0] r_exp_p0;
  cls_e              r_cls_p0;
  logic [MAN_W-1:0]  r_mn_p0;
  logic [FRAC_W-1:0] r_d_p0;
  logic [XW-1:0]     r_x_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign_p0 <= 1'b0;
      r_exp_p0  <= '0;
      r_cls_p0  <= NORMAL;
      r_mn_p0   <= '0;
      r_d_p0    <= '0;
      r_x_p0    <= '0;
    end else begin
      r_sign_p0 <= numerator[31] ^ divisor[31];
      r_exp_p0  <= w_exp_p0;
      r_cls_p0  <= w_cls_p0;
      r_mn_p0   <= w_n_frac;
      r_d_p0    <= w_d_fx;
      r_x_p0    <= w_x0;
    end
  end

  logic              w_sign [ITERATIONS+1];
  logic signed [9:0] w_exp  [ITERATIONS+1];
  cls_e              w_cls  [ITERATIONS+1];
  logic [MAN_W-1:0]  w_mn   [ITERATIONS+1];
  logic [FRAC_W-1:0] w_d    [ITERATIONS+1];
  logic [XW-1:0]     w_x    [ITERATIONS+1];

  assign w_sign[0] = r_sign_p0;
  assign w_exp[0]  = r_exp_p0;
  assign w_cls[0]  = r_cls_p0;
  assign w_mn[0]   = r_mn_p0;
  assign w_d[0]    = r_d_p0;
  assign w_x[0]    = r_x_p0;

  generate
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_nr
      nr_stage #(.FRAC_W(FRAC_W)) u_nr (
        .clk    (clk),
        .rst    (rst),
        .i_sign (w_sign[g]),
        .i_exp  (w_exp[g]),
        .i_cls  (w_cls[g]),
        .i_mn   (w_mn[g]),
        .i_d    (w_d[g]),
        .i_x    (w_x[g]),
        .o_sign (w_sign[g+1]),
        .o_exp  (w_exp[g+1]),
        .o_cls  (w_cls[g+1]),
        .o_mn   (w_mn[g+1]),
        .o_d    (w_d[g+1]),
        .o_x    (w_x[g+1])
      );
    end
  endgenerate

  // A zero divisor fraction means D is exactly 0.5, so the reciprocal is forced to exactly 2.0.
  logic [XW-1:0] w_x_sel;
  logic [PW-1:0] w_prod;

  assign w_x_sel = (w_d[ITERATIONS] == HALF) ? TWO : w_x[ITERATIONS];
  assign w_prod  = PW'({{XW{1'b0}}, 1'b1, w_mn[ITERATIONS]} * {{(MAN_W+1){1'b0}}, w_x_sel});

  // Multiply stage boundary
  logic              r_sign_p1;
  logic signed [9:0] r_exp_p1;
  cls_e              r_cls_p1;
  logic [PW-1:0]     r_prod_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign_p1 <= 1'b0;
      r_exp_p1  <= '0;
      r_cls_p1  <= NORMAL;
      r_prod_p1 <= '0;
    end else begin
      r_sign_p1 <= w_sign[ITERATIONS];
      r_exp_p1  <= w_exp[ITERATIONS];
      r_cls_p1  <= w_cls[ITERATIONS];
      r_prod_p1 <= w_prod;
    end
  end

  logic              w_hi;
  logic [MAN_W-1:0]  w_frac;
  logic              w_guard, w_sticky;
  logic [MAN_W:0]    w_rnd;
  logic signed [9:0] w_exp_fin;

  assign w_hi      = r_prod_p1[PW-1];
  assign w_frac    = w_hi ? r_prod_p1[PW-2 -: MAN_W] : r_prod_p1[PW-3 -: MAN_W];
  assign w_guard   = w_hi ? r_prod_p1[PW-2-MAN_W]    : r_prod_p1[PW-3-MAN_W];
  assign w_sticky  = w_hi ? |r_prod_p1[PW-3-MAN_W:0] : |r_prod_p1[PW-4-MAN_W:0];
  assign w_rnd     = round_rne(w_frac, w_guard, w_sticky);
  assign w_exp_fin = r_exp_p1 + $signed({9'd0, w_hi}) + $signed({9'd0, w_rnd[MAN_W]});

  // Output stage boundary: normalised, rounded, packed quotient
  always_ff @(posedge clk) begin
    if (rst) reciprocal1 <= '0;
    else     reciprocal1 <= pack_fp(r_sign_p1, r_cls_p1, w_exp_fin, w_rnd[MAN_W-1:0]);
  end
endmodule

// File: tb/tb_reciprocal.sv
// Bench for the pipelined binary32 divider against an exact integer-division reference.
module tb_reciprocal;
  localparam int LAT = 6;
  localparam int ND  = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] numerator = '0;
  logic [31:0] divisor = '0;
  logic [31:0] reciprocal1;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  reciprocal #(.ITERATIONS(3), .FRAC_W(30)) dut (
    .clk         (clk),
    .rst         (rst),
    .numerator   (numerator),
    .divisor     (divisor),
    .reciprocal1 (reciprocal1)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] DN [ND] = '{
    32'h3F800000, 32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
    32'h00000000, 32'h3F800000, 32'hFFC00001, 32'h7F800000, 32'h7F800000, 32'hBF800000,
    32'h80000000, 32'h3F800000, 32'h00000001, 32'h7F000000, 32'h00800000, 32'h3F800000};
  localparam logic [31:0] DD [ND] = '{
    32'h41000000, 32'h40000000, 32'h3FC00000, 32'h40400000, 32'hC0400000, 32'h00000000,
    32'h00000000, 32'h7F800000, 32'h3F800000, 32'h7F800000, 32'hC0000000, 32'h00000000,
    32'h40000000, 32'h00000001, 32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3F800000};
  localparam logic [31:0] DQ [ND] = '{
    32'h3E000000, 32'h3F000000, 32'h40000000, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'h7F800000,
    32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'hFF800000,
    32'h80000000, 32'h7F800000, 32'h00000000, 32'h7F800000, 32'h00000000, 32'h3F800000};
  localparam bit DT [ND] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  localparam logic [31:0] BN [8] = '{
    32'h3F800000, 32'h40A00000, 32'hC1200000, 32'h3F800000,
    32'h42C80000, 32'h3DCCCCCD, 32'h40490FDB, 32'hBF800000};
  localparam logic [31:0] BD [8] = '{
    32'h40400000, 32'h40E00000, 32'h40800000, 32'h41100000,
    32'hC0C00000, 32'h3F000000, 32'h402DF854, 32'h40A00000};

  // Correctly rounded quotient from exact integer division of the significands.
  function automatic logic [31:0] ref_div(input logic [31:0] n, input logic [31:0] d);
    logic s;
    int en, ed, e;
    longint unsigned mn, md, num, q, r;
    bit n_z, d_z, n_i, d_i, n_n, d_n;
    s   = n[31] ^ d[31];
    en  = int'(n[30:23]);
    ed  = int'(d[30:23]);
    n_z = (en == 0);
    d_z = (ed == 0);
    n_i = (en == 255) && (n[22:0] == 0);
    d_i = (ed == 255) && (d[22:0] == 0);
    n_n = (en == 255) && (n[22:0] != 0);
    d_n = (ed == 255) && (d[22:0] != 0);
    if (n_n || d_n || (n_z && d_z) || (n_i && d_i)) return 32'h7FC00000;
    if (d_z || n_i) return {s, 31'h7F800000};
    if (d_i || n_z) return {s, 31'd0};
    mn = 64'({1'b1, n[22:0]});
    md = 64'({1'b1, d[22:0]});
    e  = en - ed + 127;
    if (mn < md) begin
      num = mn << 24;
      e   = e - 1;
    end else begin
      num = mn << 23;
    end
    q = num / md;
    r = num % md;
    if ((2 * r > md) || ((2 * r == md) && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    if (e > 254) return {s, 31'h7F800000};
    if (e < 1)   return {s, 31'd0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic int unsigned ulp_dist(input logic [31:0] a, input logic [31:0] b);
    if (a[31] !== b[31]) return 32'hFFFF_FFFF;
    return (a[30:0] > b[30:0]) ? 32'(a[30:0] - b[30:0]) : 32'(b[30:0] - a[30:0]);
  endfunction

  function automatic logic [31:0] rand_fp(input int lo, input int hi);
    logic [22:0] f;
    f = 23'($urandom());
    if ($urandom_range(7, 0) == 0) f = '0;
    return {1'($urandom_range(1, 0)), 8'($urandom_range(hi, lo)), f};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    numerator = 32'h3F800000;
    divisor   = 32'h41000000;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (reciprocal1 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold: got %08h expected 00000000", reciprocal1);
    end
    rst = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      n_cmp++;
      if (k < LAT) begin
        if (reciprocal1 !== 32'h0) begin
          n_err++;
          $display("FAIL reset_release_cycle%0d: got %08h expected 00000000", k, reciprocal1);
        end
      end else if (reciprocal1 !== 32'h3E000000) begin
        n_err++;
        $display("FAIL first_result: got %08h expected 3E000000", reciprocal1);
      end
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < ND; i++) begin
      @(negedge clk);
      numerator = DN[i];
      divisor   = DD[i];
      repeat (LAT) @(negedge clk);
      n_cmp++;
      if (DT[i] ? (ulp_dist(reciprocal1, DQ[i]) > 1) : (reciprocal1 !== DQ[i])) begin
        n_err++;
        $display("FAIL directed%0d %08h/%08h: got %08h expected %08h", i, DN[i], DD[i],
                 reciprocal1, DQ[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    exp_q.delete();
    for (int j = 0; j < LAT + 8; j++) begin
      @(negedge clk);
      if (j >= LAT) begin
        want = exp_q.pop_front();
        n_cmp++;
        if (ulp_dist(reciprocal1, want) > 1) begin
          n_err++;
          $display("FAIL back_to_back%0d: got %08h expected %08h", j - LAT, reciprocal1, want);
        end
      end
      if (j < 8) begin
        numerator = BN[j];
        divisor   = BD[j];
        exp_q.push_back(ref_div(BN[j], BD[j]));
      end
    end
  endtask

  task automatic test_random(input int nops);
    logic [31:0] want, a, b;
    exp_q.delete();
    for (int j = 0; j < nops + LAT; j++) begin
      @(negedge clk);
      if (j >= LAT) begin
        want = exp_q.pop_front();
        n_cmp++;
        if (ulp_dist(reciprocal1, want) > 1) begin
          n_err++;
          $display("FAIL random%0d: got %08h expected %08h", j - LAT, reciprocal1, want);
        end
      end
      if (j < nops) begin
        a = rand_fp(80, 175);
        b = rand_fp(80, 175);
        numerator = a;
        divisor   = b;
        exp_q.push_back(ref_div(a, b));
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] want, a, b;
    exp_q.delete();
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j >= LAT) begin
        want = exp_q.pop_front();
        n_cmp++;
        if (ulp_dist(reciprocal1, want) > 1) begin
          n_err++;
          $display("FAIL pre_reset%0d: got %08h expected %08h", j - LAT, reciprocal1, want);
        end
      end
      a = rand_fp(80, 175);
      b = rand_fp(80, 175);
      numerator = a;
      divisor   = b;
      exp_q.push_back(ref_div(a, b));
    end
    @(negedge clk);
    rst = 1'b1;
    numerator = rand_fp(80, 175);
    divisor   = rand_fp(80, 175);
    exp_q.delete();
    for (int k = 0; k < LAT + 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (k < LAT) begin
        if (reciprocal1 !== 32'h0) begin
          n_err++;
          $display("FAIL flush_cycle%0d: got %08h expected 00000000", k, reciprocal1);
        end
      end else begin
        want = exp_q.pop_front();
        if (ulp_dist(reciprocal1, want) > 1) begin
          n_err++;
          $display("FAIL post_reset%0d: got %08h expected %08h", k - LAT, reciprocal1, want);
        end
      end
      if (k == 0) rst = 1'b0;
      a = rand_fp(80, 175);
      b = rand_fp(80, 175);
      numerator = a;
      divisor   = b;
      exp_q.push_back(ref_div(a, b));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random(300);
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
